bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter for the shared burst bus used by the DMA custom-instruction masters (ramDmaCi and peers). It collects `requestTransaction` lines, issues the single-cycle `transactionGranted` pulse those masters expect, and tracks bus ownership until the transaction ends. A watchdog aborts stalled owners so that no master can hang the bus.

## Interface
- `NUM_MASTERS`, 4: number of requesting masters (2..8).
- `BEGIN_TIMEOUT`, 16: cycles a granted master has to assert `beginTransactionIn`.
- `BUS_TIMEOUT`, 1024: maximum cycles from begin to end before abort.
- `clock` input 1: single system clock, all logic on the rising edge.
- `reset` input 1: asynchronous, active-low; asserting it clears all state immediately.
- `requests` input NUM_MASTERS: per-master `requestTransaction`, level.
- `grants` output NUM_MASTERS: per-master `transactionGranted`, one-hot, one-cycle pulse.
- `beginTransactionIn` input 1: OR of the masters' `beginTransactionOut`.
- `endTransactionIn` input 1: bus end-of-transaction, from the slave or the owning master.
- `busErrorIn` input 1: bus error from the slave.
- `endTransactionOut` output 1: arbiter-generated end, pulsed only on watchdog abort.
- `busErrorOut` output 1: arbiter-generated error, pulsed together with `endTransactionOut` on abort.
- `busBusy` output 1: high from the grant cycle until ownership is released.
- `activeMaster` output clog2(NUM_MASTERS): index of the current or last owner.

## Operation
- Reset values are all zero: `grants`, `endTransactionOut`, `busErrorOut`, `busBusy`, `activeMaster`, the priority pointer and the counters. The state is IDLE.
- FSM states: IDLE, GRANT, WAIT_BEGIN, OWNED, ABORT.
- **IDLE:** if any `requests` bit is set, select the first set bit searching from the pointer upward with wrap-around.
  - Latch the selected index into `activeMaster`.
  - Go to GRANT.
- **GRANT:** `grants[activeMaster]` = 1 for exactly this cycle and `busBusy` = 1.
  - Set the pointer to (activeMaster+1) mod NUM_MASTERS.
  - Clear the counter. Go to WAIT_BEGIN.
- **WAIT_BEGIN:** when `beginTransactionIn` = 1, clear the counter and go to OWNED.
  - Otherwise increment the counter. At BEGIN_TIMEOUT-1, go to IDLE silently (the master abandoned the grant).
- **OWNED:** when `endTransactionIn` = 1 or `busErrorIn` = 1, go to IDLE.
  - Otherwise increment the counter. At BUS_TIMEOUT-1, go to ABORT.
- **ABORT:** `endTransactionOut` = 1 and `busErrorOut` = 1 for one cycle, then go to IDLE.
- A master dropping `requests` after its grant has no effect; ownership is ended only by end, error or timeout.
- Counters are clog2(BUS_TIMEOUT) bits wide, saturate-free, and are compared against the constant minus 1.

## Timing
- Request to grant: a request sampled high in IDLE at edge k produces the grant pulse in cycle k+1.
- Minimum inter-grant gap: end sampled at edge m, IDLE in cycle m+1, next grant in cycle m+2. That is 2 cycles of bus turnaround.
- `busBusy` drops in the cycle after end, error or ABORT is sampled.
- Simultaneous events:
  - `beginTransactionIn` and `endTransactionIn` in the same WAIT_BEGIN cycle: take the begin, then end normally on the next sample.
  - `endTransactionIn` in the same cycle the counter reaches BUS_TIMEOUT-1: the end wins and there is no abort.
- `endTransactionIn` or `busErrorIn` seen in IDLE, GRANT or WAIT_BEGIN: ignored.
- Reset asserted mid-transaction: all outputs go to 0 asynchronously. After release the FSM is in IDLE with the pointer at 0.
- Outputs are registered, with no combinational path from input to output.

## Test plan
- Single request: `requests`=0001 held → `grants`=0001 for exactly 1 cycle, 1 cycle after sampling. Then begin, 6 data cycles, end → `busBusy` high through the end cycle and low one cycle after.
- Round-robin: `requests`=1111 held, each owner ends after 3 cycles → grant order is masters 0,1,2,3,0 with 2-cycle turnaround gaps.
- Begin timeout: grant master 2, never assert begin → after 16 cycles back to IDLE, no error pulse, next grant goes to master 3 if it is requesting.
- Bus watchdog: BUS_TIMEOUT=32, begin then no end → `endTransactionOut` and `busErrorOut` pulse 1 cycle at cycle 32 of OWNED, then re-arbitration.
- Boundary: end in the same cycle as the counter reaches 31 → no abort pulse. A slave `busErrorIn` in OWNED → immediate release with no arbiter error pulse.
- Reset mid-OWNED: assert `reset`=0 asynchronously (between edges) → all outputs 0 before the next edge. After release, `requests`=0100 → grant to master 2.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: request/grant lines plus the shared burst-bus
// control signals seen by the arbiter. The slave modport is the arbiter's
// view and the master modport is the view of the requesting masters and the bus.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int AW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] requests;
  logic [NUM_MASTERS-1:0] grants;
  logic                   beginTransactionIn;
  logic                   endTransactionIn;
  logic                   busErrorIn;
  logic                   endTransactionOut;
  logic                   busErrorOut;
  logic                   busBusy;
  logic [AW-1:0]          activeMaster;

  modport slave (
    input  requests, beginTransactionIn, endTransactionIn, busErrorIn,
    output grants, endTransactionOut, busErrorOut, busBusy, activeMaster
  );

  modport master (
    output requests, beginTransactionIn, endTransactionIn, busErrorIn,
    input  grants, endTransactionOut, busErrorOut, busBusy, activeMaster
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared burst bus. Grants one master at a time
// with a single-cycle pulse, tracks ownership until end/error, and aborts
// owners that stall with an arbiter-generated end + error pulse.
// BEGIN_TIMEOUT must not exceed BUS_TIMEOUT (both share one counter).
module bus_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int BEGIN_TIMEOUT = 16,
  parameter int BUS_TIMEOUT   = 1024
) (
  input  logic           clock,
  input  logic           reset,
  bus_arbiter_if.slave   bus
);
  localparam int AW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(BUS_TIMEOUT);
  localparam logic [CW-1:0] BEGIN_LAST = CW'(BEGIN_TIMEOUT - 1);
  localparam logic [CW-1:0] BUS_LAST   = CW'(BUS_TIMEOUT - 1);
  localparam logic [AW:0]   NM_W       = (AW+1)'(NUM_MASTERS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {
    IDLE, GRANT, WAIT_BEGIN, OWNED, ABORT
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          active_q, active_d;
  logic [NUM_MASTERS-1:0] grants_q, grants_d;
  logic                   busy_q, busy_d;
  logic                   end_out_q, end_out_d;
  logic                   err_out_q, err_out_d;

  logic [AW:0]            cand;
  logic [AW-1:0]          sel_idx;
  logic                   sel_found;
  logic [AW-1:0]          next_ptr;

  // Pick the first requesting master at or above the pointer, wrapping around
  always_comb begin
    cand      = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, ptr_q} + (AW+1)'(i);
      if (cand >= NM_W) begin
        cand = cand - NM_W;
      end
      if (!sel_found && bus.requests[cand[AW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[AW-1:0];
      end
    end
  end

  assign next_ptr = (active_q == LAST_IDX) ? '0 : active_q + AW'(1);

  // Next-state logic for the arbitration/ownership FSM and its counter
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (|bus.requests) begin
          active_d = sel_idx;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        ptr_d   = next_ptr;
        cnt_d   = '0;
        state_d = WAIT_BEGIN;
      end
      WAIT_BEGIN: begin
        // Begin takes priority over the timeout; end/error are ignored here
        if (bus.beginTransactionIn) begin
          cnt_d   = '0;
          state_d = OWNED;
        end else if (cnt_q == BEGIN_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OWNED: begin
        // A normal end on the final counter value wins over the watchdog
        if (bus.endTransactionIn || bus.busErrorIn) begin
          state_d = IDLE;
        end else if (cnt_q == BUS_LAST) begin
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
      assign grants_d[gi] = (state_d == GRANT) && (active_d == AW'(gi));
    end
  endgenerate

  assign busy_d    = (state_d != IDLE);
  assign end_out_d = (state_d == ABORT);
  assign err_out_d = (state_d == ABORT);

  // State, pointer, counter and output registers; reset clears everything at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      grants_q  <= '0;
      busy_q    <= 1'b0;
      end_out_q <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      grants_q  <= grants_d;
      busy_q    <= busy_d;
      end_out_q <= end_out_d;
      err_out_q <= err_out_d;
    end
  end

  assign bus.grants            = grants_q;
  assign bus.busBusy           = busy_q;
  assign bus.endTransactionOut = end_out_q;
  assign bus.busErrorOut       = err_out_q;
  assign bus.activeMaster      = active_q;
endmodule
